sha3_block_padder: RTL and testbench



---
 rtl/sha3_block_padder.sv | 201 ++++++++++++++++++++
 tb/tb_sha3_block_padder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha3_block_padder.sv
// SHA3 block padder: packs DATA_WIDTH-bit message words into one Keccak rate
// block, applies pad10*1 padding (domain 0x06, final 0x80) and hands complete
// blocks to the permutation core over a valid/ready handshake.
// Optional macro SHA3_PADDER_KECCAK_LEGACY_EN adds legacy_keccak (domain 0x01).
module sha3_block_padder #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RATE_MAX   = 1152
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  input  logic [DATA_WIDTH/8-1:0] s_keep,
  input  logic [1:0]              sha_mode,
`ifdef SHA3_PADDER_KECCAK_LEGACY_EN
  input  logic                    legacy_keccak,
`endif
  output logic                    s_ready,
  output logic [RATE_MAX-1:0]     blk_data,
  output logic                    blk_valid,
  input  logic                    blk_ready,
  output logic                    blk_last,
  output logic [7:0]              blk_rate_bytes
);

  localparam int unsigned NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PAD, S_EMIT} state_t;

  function automatic logic [7:0] rate_of(input logic [1:0] mode);
    case (mode)
      2'd0:    return 8'd144;
      2'd1:    return 8'd136;
      2'd2:    return 8'd104;
      default: return 8'd72;
    endcase
  endfunction

  state_t                state_q, state_d;
  logic [RATE_MAX-1:0]   buf_q, buf_d;
  logic [7:0]            pos_q, pos_d;
  logic [7:0]            rate_q, rate_d;
  logic                  pad_pending_q, pad_pending_d;
  logic                  in_msg_q, in_msg_d;
  logic                  s_ready_q, s_ready_d;
  logic                  blk_valid_q, blk_valid_d;
  logic                  blk_last_q, blk_last_d;
`ifdef SHA3_PADDER_KECCAK_LEGACY_EN
  logic                  legacy_q, legacy_d;
`endif

  logic                  beat;
  logic                  found;
  logic [7:0]            rate_cur;
  logic [7:0]            k;
  logic [7:0]            nbytes;
  logic [8:0]            sum;
  logic [7:0]            dom;
  logic [DATA_WIDTH-1:0] data_m;
  logic [RATE_MAX-1:0]   beat_vec;
  logic [RATE_MAX-1:0]   pad_vec;

  assign s_ready        = s_ready_q;
  assign blk_data       = buf_q;
  assign blk_valid      = blk_valid_q;
  assign blk_last       = blk_last_q;
  assign blk_rate_bytes = rate_q;

  // Next-state, buffer packing and padding logic
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    pos_d         = pos_q;
    rate_d        = rate_q;
    pad_pending_d = pad_pending_q;
    in_msg_d      = in_msg_q;
    s_ready_d     = s_ready_q;
    blk_valid_d   = blk_valid_q;
    blk_last_d    = blk_last_q;
`ifdef SHA3_PADDER_KECCAK_LEGACY_EN
    legacy_d      = legacy_q;
    dom           = legacy_q ? 8'h01 : 8'h06;
`else
    dom           = 8'h06;
`endif

    beat     = s_valid && s_ready_q;
    rate_cur = in_msg_q ? rate_q : rate_of(sha_mode);

    // Byte count of a last beat is the index of the lowest cleared keep bit
    k     = 8'(NB);
    found = 1'b0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (!found && !s_keep[i]) begin
        k     = 8'(i);
        found = 1'b1;
      end
    end
    nbytes = s_last ? k : 8'(NB);
    sum    = {1'b0, pos_q} + {1'b0, nbytes};

    // Unused bytes are zeroed so the beat can simply be OR-ed into the
    // already-cleared region of the buffer above pos.
    data_m = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (8'(i) < nbytes) data_m[i*8 +: 8] = s_data[i*8 +: 8];
    end
    beat_vec = RATE_MAX'(data_m) << {pos_q, 3'b000};
    pad_vec  = (RATE_MAX'(dom) << {pos_q, 3'b000})
             | (RATE_MAX'(8'h80) << {rate_q - 8'd1, 3'b000});

    case (state_q)
      S_IDLE: begin
        buf_d     = '0;
        pos_d     = '0;
        in_msg_d  = 1'b0;
        s_ready_d = 1'b1;
        state_d   = S_FILL;
      end
      S_FILL: begin
        if (beat) begin
          if (!in_msg_q) begin
            in_msg_d = 1'b1;
            rate_d   = rate_of(sha_mode);
`ifdef SHA3_PADDER_KECCAK_LEGACY_EN
            legacy_d = legacy_keccak;
`endif
          end
          buf_d = buf_q | beat_vec;
          pos_d = sum[7:0];
          if (sum == {1'b0, rate_cur}) begin
            state_d       = S_EMIT;
            s_ready_d     = 1'b0;
            blk_valid_d   = 1'b1;
            blk_last_d    = 1'b0;
            pad_pending_d = s_last;
          end else if (s_last) begin
            state_d   = S_PAD;
            s_ready_d = 1'b0;
          end
        end
      end
      S_PAD: begin
        buf_d       = buf_q | pad_vec;
        blk_valid_d = 1'b1;
        blk_last_d  = 1'b1;
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (blk_ready) begin
          blk_valid_d = 1'b0;
          buf_d       = '0;
          pos_d       = '0;
          if (pad_pending_q) begin
            pad_pending_d = 1'b0;
            state_d       = S_PAD;
          end else if (blk_last_q) begin
            state_d = S_IDLE;
          end else begin
            s_ready_d = 1'b1;
            state_d   = S_FILL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q       <= S_IDLE;
      buf_q         <= '0;
      pos_q         <= '0;
      rate_q        <= '0;
      pad_pending_q <= 1'b0;
      in_msg_q      <= 1'b0;
      s_ready_q     <= 1'b0;
      blk_valid_q   <= 1'b0;
      blk_last_q    <= 1'b0;
`ifdef SHA3_PADDER_KECCAK_LEGACY_EN
      legacy_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      pos_q         <= pos_d;
      rate_q        <= rate_d;
      pad_pending_q <= pad_pending_d;
      in_msg_q      <= in_msg_d;
      s_ready_q     <= s_ready_d;
      blk_valid_q   <= blk_valid_d;
      blk_last_q    <= blk_last_d;
`ifdef SHA3_PADDER_KECCAK_LEGACY_EN
      legacy_q      <= legacy_d;
`endif
    end
  end

endmodule

// File: tb/tb_sha3_block_padder.sv
// Bench for sha3_block_padder: byte-queue pad10*1 model, per-cycle block
// compare with stability checks under backpressure, directed and random messages.
module tb_sha3_block_padder;

  localparam int DW = 16;
  localparam int NB = DW / 8;
  localparam int RM = 1152;

  typedef struct {
    logic [RM-1:0] data;
    bit            last;
    int            rate;
  } blk_t;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [NB-1:0] s_keep = '0;
  logic [1:0]    sha_mode = '0;
  logic          s_ready;
  logic [RM-1:0] blk_data;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic          blk_last;
  logic [7:0]    blk_rate_bytes;

  int   total = 0;
  int   bad   = 0;
  bit   hold  = 1'b0;
  blk_t exp_q[$];
  blk_t bq[$];
  byte unsigned mq[$];

  sha3_block_padder #(.DATA_WIDTH(DW), .RATE_MAX(RM)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_keep(s_keep),
    .sha_mode(sha_mode),
`ifdef SHA3_PADDER_KECCAK_LEGACY_EN
    .legacy_keccak(1'b0),
`endif
    .s_ready(s_ready), .blk_data(blk_data), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_last(blk_last), .blk_rate_bytes(blk_rate_bytes)
  );

  always #5 ACLK = ~ACLK;

  function automatic int rate_of(input int m);
    case (m)
      0: return 144;
      1: return 136;
      2: return 104;
      default: return 72;
    endcase
  endfunction

  // Model: append pad10*1 to the message bytes, cut into rate-sized blocks.
  function automatic void build(input int rate, input byte unsigned m[$]);
    byte unsigned p[$];
    int pad;
    blk_t b;
    bq.delete();
    p = m;
    pad = rate - (m.size() % rate);
    if (pad == 1) p.push_back(8'h86);
    else begin
      p.push_back(8'h06);
      for (int i = 0; i < pad - 2; i++) p.push_back(8'h00);
      p.push_back(8'h80);
    end
    for (int n = 0; n < p.size() / rate; n++) begin
      b.data = '0;
      for (int j = 0; j < rate; j++) b.data[j*8 +: 8] = p[n*rate + j];
      b.last = (n == p.size() / rate - 1);
      b.rate = rate;
      bq.push_back(b);
    end
  endfunction

  function automatic void fill(input int len, input int val);
    mq.delete();
    for (int i = 0; i < len; i++) mq.push_back((val < 0) ? 8'($urandom) : 8'(val));
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic chk_data(input string name, input logic [RM-1:0] got, input logic [RM-1:0] want);
    int idx;
    total++;
    if (got !== want) begin
      bad++;
      idx = 0;
      for (int j = RM/8 - 1; j >= 0; j--) if (got[j*8 +: 8] !== want[j*8 +: 8]) idx = j;
      $display("FAIL %s first differing byte %0d got=%02h want=%02h",
               name, idx, got[idx*8 +: 8], want[idx*8 +: 8]);
    end
  endtask

  task automatic model_byte(input string name, input int blk, input int j, input logic [7:0] want);
    chk(name, {56'd0, bq[blk].data[j*8 +: 8]}, {56'd0, want});
  endtask

  // Permutation-core side: random ready unless the bench is holding it off
  initial forever begin
    @(posedge ACLK); #1;
    blk_ready = hold ? 1'b0 : ($urandom % 3 != 0);
  end

  // Compare process: every handshake against the model, and hold-stability
  initial begin
    bit pv = 1'b0;
    blk_t pb;
    blk_t e;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) pv = 1'b0;
      else begin
        if (pv) begin
          chk("hold_valid", {63'd0, blk_valid}, 64'd1);
          chk_data("hold_data", blk_data, pb.data);
          chk("hold_last", {63'd0, blk_last}, {63'd0, pb.last});
          chk("hold_rate", {56'd0, blk_rate_bytes}, 64'(pb.rate));
        end
        pv = 1'b0;
        if (blk_valid) begin
          chk("s_ready_in_emit", {63'd0, s_ready}, 64'd0);
          if (blk_ready) begin
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL extra_block got=1 want=0");
            end else begin
              e = exp_q.pop_front();
              chk_data("blk_data", blk_data, e.data);
              chk("blk_last", {63'd0, blk_last}, {63'd0, e.last});
              chk("blk_rate", {56'd0, blk_rate_bytes}, 64'(e.rate));
            end
          end else begin
            pv = 1'b1;
            pb.data = blk_data; pb.last = blk_last; pb.rate = int'(blk_rate_bytes);
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge ACLK);
    while (!s_ready) begin
      n++;
      if (n > 3000) begin
        $display("FAIL s_ready_timeout got=0 want=1");
        $fatal(1, "timeout");
      end
      @(negedge ACLK);
    end
  endtask

  // Drive one beat; keep/data bytes beyond the valid ones are random junk
  task automatic drive_beat(input int first_mode, input bit last, input int k, input int base);
    for (int i = 0; i < NB; i++)
      s_data[i*8 +: 8] = (i < k) ? mq[base + i] : 8'($urandom);
    if (!last || k == NB) s_keep = last ? '1 : NB'($urandom);
    else s_keep = NB'((1 << k) - 1) | NB'($urandom << (k + 1));
    s_last   = last;
    sha_mode = (first_mode >= 0) ? 2'(first_mode) : 2'($urandom);
    s_valid  = 1'b1;
    wait_ready();
    @(posedge ACLK); #1;
  endtask

  task automatic send_msg(input int mode);
    int len = mq.size();
    int rate = rate_of(mode);
    int beats = (len == 0) ? 1 : (len + NB - 1) / NB;
    build(rate, mq);
    foreach (bq[i]) exp_q.push_back(bq[i]);
    for (int b = 0; b < beats; b++) begin
      if ($urandom % 5 == 0) begin
        s_valid = 1'b0; sha_mode = 2'($urandom);
        @(posedge ACLK); #1;
      end
      drive_beat((b == 0) ? mode : -1, b == beats - 1,
                 (b == beats - 1) ? len - b * NB : NB, b * NB);
    end
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge ACLK);
    if (len > 0 && len % rate == 0) chk("lat_full_valid", {63'd0, blk_valid}, 64'd1);
    else begin
      chk("lat_pad_cycle", {63'd0, blk_valid}, 64'd0);
      @(negedge ACLK);
      chk("lat_pad_valid", {63'd0, blk_valid}, 64'd1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || blk_valid) && n < 5000) begin
      @(negedge ACLK); n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_blk_valid", {63'd0, blk_valid}, 64'd0);
    chk("rst_blk_last", {63'd0, blk_last}, 64'd0);
    chk_data("rst_blk_data", blk_data, '0);
    chk("rst_rate", {56'd0, blk_rate_bytes}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lens[7];
    int mode;

    // Pin the model to hand-computed blocks
    fill(0, 0); build(136, mq);
    chk("model_empty_n", 64'(bq.size()), 64'd1);
    model_byte("model_empty_b0", 0, 0, 8'h06);
    model_byte("model_empty_b135", 0, 135, 8'h80);
    mq = '{8'h61, 8'h62, 8'h63}; build(136, mq);
    model_byte("model_abc_b2", 0, 2, 8'h63);
    model_byte("model_abc_b3", 0, 3, 8'h06);
    model_byte("model_abc_b135", 0, 135, 8'h80);
    fill(135, 8'hAA); build(136, mq);
    model_byte("model_135_b134", 0, 134, 8'hAA);
    model_byte("model_135_b135", 0, 135, 8'h86);
    fill(72, 8'h55); build(72, mq);
    chk("model_72_n", 64'(bq.size()), 64'd2);
    chk("model_72_last0", {63'd0, bq[0].last}, 64'd0);
    model_byte("model_72_b71", 0, 71, 8'h55);
    model_byte("model_72_2b0", 1, 0, 8'h06);
    model_byte("model_72_2b71", 1, 71, 8'h80);
    model_byte("model_72_2b72", 1, 72, 8'h00);

    // Reset state
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk_reset_outputs();
    ARESETn = 1'b1;

    // Directed: empty, "abc", 135 bytes, two-block 72 bytes
    fill(0, 0);       send_msg(1);
    mq = '{8'h61, 8'h62, 8'h63}; send_msg(1);
    fill(135, 8'hAA); send_msg(1);
    fill(72, 8'h55);  send_msg(3);
    drain();

    // Backpressure: ready held low for five cycles while a block is offered
    hold = 1'b1;
    fill(5, -1); send_msg(1);
    repeat (5) begin
      @(negedge ACLK);
      chk("bp_valid", {63'd0, blk_valid}, 64'd1);
      chk("bp_s_ready", {63'd0, s_ready}, 64'd0);
    end
    chk("bp_not_consumed", 64'(exp_q.size()), 64'd1);
    hold = 1'b0;
    drain();

    // Abort a SHA3-224 message after 10 beats, then an empty SHA3-384 message
    fill(20, 8'hC3);
    for (int b = 0; b < 10; b++) drive_beat((b == 0) ? 0 : -1, 1'b0, NB, b * NB);
    s_valid = 1'b0;
    ARESETn = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk_reset_outputs();
    ARESETn = 1'b1;
    fill(0, 0); send_msg(2);
    drain();

    // Random messages around block boundaries
    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 3);
      lens = '{0, 1, rate_of(mode) - 1, rate_of(mode), rate_of(mode) + 1,
               2 * rate_of(mode) - 1, $urandom_range(0, 300)};
      fill(lens[$urandom_range(0, 6)], -1);
      send_msg(mode);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
